id_ex_pipe_reg: RTL and testbench



---
 rtl/id_ex_pipe_reg.sv | 191 +++++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_reg
// Purpose  : Decode-to-execute pipeline register with valid/ready handshake,
//            one-entry skid buffer, synchronous flush and hazard-unit tags.
//            Optional performance counters enabled by macro STAGE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int ALUCTRL_WIDTH   = 3,
  parameter int RESULTSRC_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       RegWriteD,
  input  logic                       MemWriteD,
  input  logic                       JumpD,
  input  logic                       BranchD,
  input  logic                       ALUSrcD,
  input  logic                       MUXJUMPD,
  input  logic                       JUMPRTD,
  input  logic                       BranchMUXD,
  input  logic [RESULTSRC_WIDTH-1:0] ResultSrcD,
  input  logic [ALUCTRL_WIDTH-1:0]   ALUControlD,
  input  logic [DATA_WIDTH-1:0]      RD1D,
  input  logic [DATA_WIDTH-1:0]      RD2D,
  input  logic [DATA_WIDTH-1:0]      ImmExtD,
  input  logic [ADDRESS_WIDTH-1:0]   PCD,
  input  logic [ADDRESS_WIDTH-1:0]   PCPlus4D,
  input  logic [REG_ADDR_WIDTH-1:0]  Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0]  Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0]  RdD,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       RegWriteE,
  output logic                       MemWriteE,
  output logic                       JumpE,
  output logic                       BranchE,
  output logic                       ALUSrcE,
  output logic                       MUXJUMPE,
  output logic                       JUMPRTE,
  output logic                       BranchMUXE,
  output logic [RESULTSRC_WIDTH-1:0] ResultSrcE,
  output logic [ALUCTRL_WIDTH-1:0]   ALUControlE,
  output logic [DATA_WIDTH-1:0]      RD1E,
  output logic [DATA_WIDTH-1:0]      RD2E,
  output logic [DATA_WIDTH-1:0]      ImmExtE,
  output logic [ADDRESS_WIDTH-1:0]   PCE,
  output logic [ADDRESS_WIDTH-1:0]   PCPlus4E,
  output logic [REG_ADDR_WIDTH-1:0]  Rs1E,
  output logic [REG_ADDR_WIDTH-1:0]  Rs2E,
  output logic [REG_ADDR_WIDTH-1:0]  RdE,
  output logic [31:0]                stall_count,
  output logic [31:0]                bubble_count
);

  localparam int c_CTRL_W = 8 + RESULTSRC_WIDTH + ALUCTRL_WIDTH;
  localparam int c_DATA_W = 3*DATA_WIDTH + 2*ADDRESS_WIDTH + 3*REG_ADDR_WIDTH;

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_FULL  = 2'd1;
  localparam logic [1:0] c_SKID  = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;

  logic [c_CTRL_W-1:0] w_d_ctrl;
  logic [c_DATA_W-1:0] w_d_data;
  logic [c_CTRL_W-1:0] r_main_ctrl;
  logic [c_DATA_W-1:0] r_main_data;
  logic [c_CTRL_W-1:0] r_skid_ctrl;
  logic [c_DATA_W-1:0] r_skid_data;

  logic w_out_valid;
  logic w_in_ready;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_load_main_d;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_d_ctrl = {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, MUXJUMPD,
                     JUMPRTD, BranchMUXD, ResultSrcD, ALUControlD};
  assign w_d_data = {RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides every transfer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_EMPTY: begin
        if (w_in_xfer) w_state_nxt = c_FULL;
      end
      c_FULL: begin
        case ({w_in_xfer, w_out_xfer})
          2'b10:   w_state_nxt = c_SKID;
          2'b01:   w_state_nxt = c_EMPTY;
          default: w_state_nxt = c_FULL;
        endcase
      end
      c_SKID: begin
        if (w_out_xfer) w_state_nxt = c_FULL;
      end
      default: w_state_nxt = c_EMPTY;
    endcase
    if (flush) w_state_nxt = c_EMPTY;
  end

  // Handshake and load-select outputs; ready depends on state only
  always_comb begin
    w_out_valid      = (r_state == c_FULL) || (r_state == c_SKID);
    w_in_ready       = (r_state != c_SKID);
    w_in_xfer        = in_valid && w_in_ready && !flush;
    w_out_xfer       = w_out_valid && out_ready;
    w_load_main_d    = w_in_xfer &&
                       ((r_state == c_EMPTY) || ((r_state == c_FULL) && w_out_xfer));
    w_load_main_skid = (r_state == c_SKID) && w_out_xfer;
    w_load_skid      = (r_state == c_FULL) && w_in_xfer && !w_out_xfer;
  end

  // Main and skid storage; both cleared so data/tags read zero after rst/flush
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_main_d) begin
        r_main_ctrl <= w_d_ctrl;
        r_main_data <= w_d_data;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= w_d_ctrl;
        r_skid_data <= w_d_data;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;

  // Controls are masked to a NOP whenever the main entry is invalid
  assign {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, MUXJUMPE,
          JUMPRTE, BranchMUXE, ResultSrcE, ALUControlE}
         = r_main_ctrl & {c_CTRL_W{w_out_valid}};
  assign {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE} = r_main_data;

`ifdef STAGE_PERF_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_bubble_count;

  // Saturating counters, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count  <= '0;
      r_bubble_count <= '0;
    end else begin
      if (w_out_valid && !out_ready && (r_stall_count != 32'hFFFF_FFFF))
        r_stall_count <= r_stall_count + 32'd1;
      if (!w_out_valid && (r_bubble_count != 32'hFFFF_FFFF))
        r_bubble_count <= r_bubble_count + 32'd1;
    end
  end

  assign stall_count  = r_stall_count;
  assign bubble_count = r_bubble_count;
`else
  assign stall_count  = 32'd0;
  assign bubble_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipe_reg
// Purpose  : Self-checking bench for id_ex_pipe_reg against a two-entry queue
//            model; perf expectations follow macro STAGE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;

  localparam int c_BUS_W  = 188;
  localparam int c_DATA_W = 175;

  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, MUXJUMPD, JUMPRTD, BranchMUXD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, MUXJUMPE, JUMPRTE, BranchMUXE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [31:0] stall_count, bubble_count;

  logic [c_BUS_W-1:0] d_bus, e_bus;
  assign d_bus = {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, MUXJUMPD, JUMPRTD,
                  BranchMUXD, ResultSrcD, ALUControlD, RD1D, RD2D, ImmExtD, PCD,
                  PCPlus4D, Rs1D, Rs2D, RdD};
  assign e_bus = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, MUXJUMPE, JUMPRTE,
                  BranchMUXE, ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE,
                  PCPlus4E, Rs1E, Rs2E, RdE};

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUSrcD(ALUSrcD), .MUXJUMPD(MUXJUMPD), .JUMPRTD(JUMPRTD), .BranchMUXD(BranchMUXD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D),
    .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RdD(RdD), .out_valid(out_valid), .out_ready(out_ready),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .MUXJUMPE(MUXJUMPE), .JUMPRTE(JUMPRTE), .BranchMUXE(BranchMUXE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .stall_count(stall_count), .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the stage is a FIFO of depth two whose head is shown on E
  logic [c_BUS_W-1:0]  q[$];
  logic [c_DATA_W-1:0] m_last = '0;
  logic [31:0]         m_stall = '0;
  logic [31:0]         m_bubble = '0;

  task automatic rand_d();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, MUXJUMPD, JUMPRTD, BranchMUXD,
     ResultSrcD, ALUControlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD}
      = r[c_BUS_W-1:0];
  endtask

  // Apply one clock of stimulus and advance the model; returns at the negedge
  task automatic tick(input logic iv, input logic ordy, input logic fl, input logic rs);
    int cnt;
    logic [c_BUS_W-1:0] d;
    in_valid = iv; out_ready = ordy; flush = fl; rst = rs;
    cnt = q.size();
    @(posedge clk);
    d = d_bus;
    if (rs) begin
      q.delete(); m_last = '0; m_stall = '0; m_bubble = '0;
    end else begin
`ifdef STAGE_PERF_EN
      if (cnt > 0 && !ordy && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (cnt == 0 && m_bubble != 32'hFFFF_FFFF) m_bubble++;
`endif
      if (fl) begin
        q.delete(); m_last = '0;
      end else begin
        if (cnt > 0 && ordy) void'(q.pop_front());
        if (iv && cnt < 2) q.push_back(d);
        if (q.size() > 0) m_last = q[0][c_DATA_W-1:0];
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rand_d();
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if (e_bus !== '0) begin miscompares++; $display("FAIL reset_e_outputs: got %h want 0", e_bus); end
    vectors++;
    if (stall_count !== 32'd0 || bubble_count !== 32'd0) begin
      miscompares++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_count, bubble_count);
    end
    in_valid = 1'b0; rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3] = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      rand_d(); PCD = pcs[i];
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (PCE !== pcs[i] || out_valid !== 1'b1) begin
        miscompares++; $display("FAIL stream_pce[%0d]: got %h/%b want %h/1", i, PCE, out_valid, pcs[i]);
      end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_skid();
    rand_d(); PCD = 32'h10;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    rand_d(); PCD = 32'h14;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_in_ready: got %b want 0", in_ready); end
    vectors++;
    if (PCE !== 32'h10) begin miscompares++; $display("FAIL skid_hold_pce: got %h want 10", PCE); end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (PCE !== 32'h14 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL skid_drain: got pce %h rdy %b want 14/1", PCE, in_ready);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    rand_d();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    rand_d();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    rand_d(); RegWriteD = 1'b1; MemWriteD = 1'b1; PCD = 32'h20;
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || RegWriteE !== 1'b0 || MemWriteE !== 1'b0) begin
      miscompares++; $display("FAIL flush_nop: got v%b rw%b mw%b want 000", out_valid, RegWriteE, MemWriteE);
    end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (PCE !== 32'h0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_dropped: got pce %h v%b want 0/0", PCE, out_valid);
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp_stall, exp_bubble;
`ifdef STAGE_PERF_EN
    exp_stall = 32'd5; exp_bubble = 32'd4;
`else
    exp_stall = 32'd0; exp_bubble = 32'd0;
`endif
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    rand_d();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (stall_count !== exp_stall) begin miscompares++; $display("FAIL perf_stall: got %0d want %0d", stall_count, exp_stall); end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bubble_count !== exp_bubble) begin miscompares++; $display("FAIL perf_bubble: got %0d want %0d", bubble_count, exp_bubble); end
  endtask

  task automatic test_random();
    logic [c_BUS_W-1:0] exp_e;
    for (int i = 0; i < 600; i++) begin
      rand_d();
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
      exp_e = (q.size() > 0) ? q[0] : {13'd0, m_last};
      vectors++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        miscompares++;
        $display("FAIL rand_handshake[%0d]: got v%b r%b want v%b r%b", i, out_valid, in_ready, q.size() > 0, q.size() < 2);
      end
      vectors++;
      if (e_bus !== exp_e) begin
        miscompares++; $display("FAIL rand_e_bus[%0d]: got %h want %h", i, e_bus, exp_e);
      end
      vectors++;
      if (stall_count !== m_stall || bubble_count !== m_bubble) begin
        miscompares++;
        $display("FAIL rand_counters[%0d]: got %0d/%0d want %0d/%0d", i, stall_count, bubble_count, m_stall, m_bubble);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rand_d();
    @(negedge clk);
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_perf();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
